dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data RAM and the memory-mapped IO (switches/LEDs) between two requesters:
//  port 0 = pipeline MEM stage, port 1 = program/data loader.
//  Round-robin grant, region decode, fixed 1-cycle response, registered LED output, synchronised switches.
//  Sits between the MEM stage/loader and the data RAM macro.
// PARAMETERS
//  ADDR_BITS  13  RAM word-index width (2**ADDR_BITS words)
//  SW_W       18  switch input width
//  LED_W      27  LED output width
// PORTS
//  clock       in   1          system clock; all state on posedge
//  reset_n     in   1          asynchronous, active-low reset
//  p0_req      in   1          port 0 request; held with addr/we/wdata until p0_gnt
//  p0_we       in   1          1 = write, 0 = read
//  p0_addr     in   64         word address (bits [31:15] select region, [63:32] ignored)
//  p0_wdata    in   64         write data
//  p0_gnt      out  1          request accepted this cycle
//  p0_ack      out  1          response pulse, exactly 1 cycle after p0_gnt
//  p0_rdata    out  64         read data, valid when p0_ack and read
//  p0_err      out  1          unmapped access, valid with p0_ack
//  p1_*        -    -          identical set for port 1
//  mem_en      out  1          RAM access strobe
//  mem_we      out  1          RAM write enable
//  mem_addr    out  ADDR_BITS  RAM word index
//  mem_wdata   out  64         RAM write data
//  mem_rdata   in   64         RAM read data, valid 1 cycle after mem_en
//  switches    in   SW_W       asynchronous board switches
//  leds        out  LED_W      LED register
// BEHAVIOUR
//  - Reset: all gnt/ack/err = 0, rdata = 0, mem_en/mem_we = 0, leds = 0,
//    switch sync flops = 0, rr pointer = port 0 preferred.
//  - Grant: combinational from req and pointer; at most one gnt per cycle.
//    Both req: the port not granted last wins. Single req: granted immediately.
//    Pointer updates only on a grant. One access accepted per cycle; back-to-back allowed.
//  - Region decode on granted addr[31:15]: 0 = RAM; 1 = IO; anything else = unmapped.
//  - RAM: mem_en = 1, mem_we = we, mem_addr = addr[ADDR_BITS-1:0]
//    (addr[14:ADDR_BITS] ignored), mem_wdata = wdata, all in grant cycle.
//  - IO offset addr[0]:
//    - 0 = switches: read returns zero-extended 2-flop-synchronised value; write ignored.
//    - 1 = LEDs: read returns zero-extended leds; write sets leds <= wdata[LED_W-1:0] at the grant edge.
//  - Unmapped: no RAM strobe, no LED change; ack with err = 1, rdata = 0.
//  - Response pipe register {valid, port, region, offset} captured at grant;
//    next cycle drives pN_ack, pN_rdata (RAM: mem_rdata, IO: captured value), pN_err.
//    Only the owning port sees ack.
//  - rdata holds last value between acks; writes ack with rdata unchanged.
//  - LED write then LED read back-to-back: the read returns the new value.
//  - Requester drops req without gnt: no side effect.
//    req must not change addr/we/wdata while pending (bench asserts).
//  - Reset mid-access: in-flight response discarded, no ack after reset release.
//  - Write to the same RAM word by both ports in consecutive cycles: the later grant wins.
// STRUCTURE
//  - Package dmem_pkg: region codes (REG_RAM, REG_IO, REG_UNMAPPED), IO offsets (IO_SW = 0, IO_LED = 1),
//    IO_BASE = 17'h1 for addr[31:15], response-pipe struct typedef.
//  - Sub-module rr_arb2: 2-input round-robin arbiter with pointer flop; top holds decode, response pipe, LED and sync regs.
// TESTING
//  1. Reset then idle: all outputs 0; leds = 0; no mem_en for 10 cycles.
//  2. p0 write 64'hDEAD_BEEF to addr 5, then read addr 5 -> gnt same cycle, ack +1, rdata 64'hDEAD_BEEF, err 0.
//  3. Both req continuously, RAM reads -> grants alternate p0, p1, p0, ...; each port's ack 1 cycle after its gnt.
//  4. p1 write 27'h5A5A5A5 to addr 32'h8001 -> leds = 27'h5A5A5A5 next edge.
//     Then switches = 18'h2AAAA, read addr 32'h8000 after 3 cycles -> rdata 64'h2AAAA.
//  5. Read addr 32'h0001_0000 (region 2) -> ack with err = 1, rdata 0, no mem_en, leds unchanged.
//  6. Assert reset_n low in the cycle after a read grant -> no ack, leds = 0.
//     After release, first grant goes to p0.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// rtl/dmem_port_arbiter_pkg.sv - region codes, IO offsets and response-pipe type for the data-memory arbiter
package dmem_pkg;

    typedef enum logic [1:0] {
        REG_RAM      = 2'd0,
        REG_IO       = 2'd1,
        REG_UNMAPPED = 2'd2
    } region_e;

    localparam logic        IO_SW   = 1'b0;
    localparam logic        IO_LED  = 1'b1;
    localparam logic [16:0] IO_BASE = 17'h1;

    typedef struct packed {
        logic    valid;
        logic    port;
        region_e region;
        logic    offset;
        logic    we;
    } rsp_t;

    function automatic region_e decode_region(input logic [16:0] page);
        if (page == 17'h0)
            return REG_RAM;
        else if (page == IO_BASE)
            return REG_IO;
        else
            return REG_UNMAPPED;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// rtl/dmem_port_arbiter_rr_arb2.sv - two-input round-robin arbiter with last-grant pointer
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt    = req;
        last_d = last_q;
        if (req == 2'b11)
            gnt = last_q ? 2'b01 : 2'b10;
        if (gnt[1])
            last_d = 1'b1;
        else if (gnt[0])
            last_d = 1'b0;
    end

    // Reset value "port 1 granted last" makes port 0 the preferred winner.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            last_q <= 1'b1;
        else
            last_q <= last_d;
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares data RAM and switch/LED IO between MEM stage (port 0) and loader (port 1)
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 13,
    parameter int SW_W      = 18,
    parameter int LED_W     = 27
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 p0_req,
    input  logic                 p0_we,
    input  logic [63:0]          p0_addr,
    input  logic [63:0]          p0_wdata,
    output logic                 p0_gnt,
    output logic                 p0_ack,
    output logic [63:0]          p0_rdata,
    output logic                 p0_err,
    input  logic                 p1_req,
    input  logic                 p1_we,
    input  logic [63:0]          p1_addr,
    input  logic [63:0]          p1_wdata,
    output logic                 p1_gnt,
    output logic                 p1_ack,
    output logic [63:0]          p1_rdata,
    output logic                 p1_err,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [63:0]          mem_wdata,
    input  logic [63:0]          mem_rdata,
    input  logic [SW_W-1:0]      switches,
    output logic [LED_W-1:0]     leds
);

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             any_gnt;
    logic             sel_we;
    logic [63:0]      sel_addr;
    logic [63:0]      sel_wdata;
    region_e          sel_region;
    logic [63:0]      rsp_rdata;
    logic             rsp_upd;
    logic             unused_addr_bits;

    rsp_t             rsp_q, rsp_d;
    logic [SW_W-1:0]  io_sw_q, io_sw_d;
    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
    logic [LED_W-1:0] leds_q, leds_d;
    logic [63:0]      rdata0_q, rdata0_d;
    logic [63:0]      rdata1_q, rdata1_d;

    // No grants while reset is held, so nothing is launched into the response pipe.
    assign req = {p1_req, p0_req} & {2{reset_n}};

    rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt)
    );

    assign unused_addr_bits = ^{sel_addr[63:32], sel_addr[14:ADDR_BITS]};

    always_comb begin
        any_gnt    = |gnt;
        sel_we     = gnt[1] ? p1_we    : p0_we;
        sel_addr   = gnt[1] ? p1_addr  : p0_addr;
        sel_wdata  = gnt[1] ? p1_wdata : p0_wdata;
        sel_region = decode_region(sel_addr[31:15]);

        mem_en    = any_gnt && (sel_region == REG_RAM);
        mem_we    = mem_en && sel_we;
        mem_addr  = sel_addr[ADDR_BITS-1:0];
        mem_wdata = sel_wdata;

        leds_d = leds_q;
        if (any_gnt && sel_region == REG_IO && sel_addr[0] == IO_LED && sel_we)
            leds_d = sel_wdata[LED_W-1:0];

        // Switches are snapshotted at grant; LEDs can be read live in the response
        // cycle because no other access can be granted alongside the read.
        io_sw_d = any_gnt ? sw_sync_q : io_sw_q;

        rsp_d.valid  = any_gnt;
        rsp_d.port   = gnt[1];
        rsp_d.region = sel_region;
        rsp_d.offset = sel_addr[0];
        rsp_d.we     = sel_we;
    end

    always_comb begin
        rsp_rdata = '0;
        if (rsp_q.region == REG_RAM)
            rsp_rdata = mem_rdata;
        else if (rsp_q.region == REG_IO)
            rsp_rdata = (rsp_q.offset == IO_LED) ? {{(64-LED_W){1'b0}}, leds_q}
                                                 : {{(64-SW_W){1'b0}}, io_sw_q};
        rsp_upd = !rsp_q.we || (rsp_q.region == REG_UNMAPPED);

        p0_gnt = gnt[0];
        p1_gnt = gnt[1];
        p0_ack = rsp_q.valid && !rsp_q.port;
        p1_ack = rsp_q.valid &&  rsp_q.port;
        p0_err = p0_ack && (rsp_q.region == REG_UNMAPPED);
        p1_err = p1_ack && (rsp_q.region == REG_UNMAPPED);

        rdata0_d = (p0_ack && rsp_upd) ? rsp_rdata : rdata0_q;
        rdata1_d = (p1_ack && rsp_upd) ? rsp_rdata : rdata1_q;
        p0_rdata = rdata0_d;
        p1_rdata = rdata1_d;
        leds     = leds_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_q     <= '0;
            io_sw_q   <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            leds_q    <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rsp_q     <= rsp_d;
            io_sw_q   <= io_sw_d;
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
            leds_q    <= leds_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

endmodule
